// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first,
// with optional two's complement operands handled by sign/magnitude.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   inp1,
  input  logic [WIDTH-1:0]   inp2,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid never drops until that transfer, and both ready and valid come only
  // from the registered state.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t               state, state_nx;
  logic [WIDTH:0]       mcand;
  logic [WIDTH:0]       mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 neg_flag;

  logic [WIDTH:0]       mag1, mag2;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_nx;

  // WIDTH+1 bits keep the magnitude of the most negative operand exact.
  assign mag1 = (is_signed && inp1[WIDTH-1]) ? ((WIDTH+1)'(0) - {inp1[WIDTH-1], inp1})
                                             : {1'b0, inp1};
  assign mag2 = (is_signed && inp2[WIDTH-1]) ? ((WIDTH+1)'(0) - {inp2[WIDTH-1], inp2})
                                             : {1'b0, inp2};

  // Magnitude product never reaches 2^(2*WIDTH), so the carry fits in sum.
  assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? mcand : '0);
  assign acc_nx = {sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_flag <= 1'b0;
      product  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= mag1;
            mplier   <= mag2;
            neg_flag <= is_signed && (inp1[WIDTH-1] ^ inp2[WIDTH-1]);
            acc      <= '0;
            cnt      <= CW'(WIDTH);
          end
        end
        CALC: begin
          acc    <= acc_nx;
          mplier <= {1'b0, mplier[WIDTH:1]};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1))
            product <= neg_flag ? ((2*WIDTH)'(0) - acc_nx) : acc_nx;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH=8 corners, stalls, ignored input,
// mid-operation reset, and an exhaustive WIDTH=4 unsigned sweep.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv8, ir8, s8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic [1:0]  st8;

  logic        iv4, ir4, s4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic [1:0]  st4;

  int n_cmp = 0;
  int n_err = 0;

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .inp1(a8), .inp2(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8),
    .dbg_state(st8)
  );

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .inp1(a4), .inp2(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4),
    .dbg_state(st4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; stall = DONE cycles with out_ready low, mess = churn inputs in CALC.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input string tag, input int stall, input bit mess);
    int lat;
    chk({tag, "_in_ready"}, 64'(ir8), 64'd1);
    iv8 = 1'b1; a8 = a; b8 = b; s8 = s; or8 = (stall == 0);
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      if (mess) begin
        iv8 = 1'b1; a8 = ~a8; b8 = b8 + 8'd3; s8 = ~s8;
        chk({tag, "_calc_in_ready"}, 64'(ir8), 64'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    iv8 = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'd8);
    chk({tag, "_product"}, 64'(p8), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_product"}, 64'(p8), 64'(exp));
      chk({tag, "_stall_out_valid"}, 64'(ov8), 64'd1);
      chk({tag, "_stall_in_ready"}, 64'(ir8), 64'd0);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_post_out_valid"}, 64'(ov8), 64'd0);
    chk({tag, "_post_in_ready"}, 64'(ir8), 64'd1);
    if (mess) begin
      @(posedge clk); #1;
      chk({tag, "_no_second_op"}, 64'(busy8), 64'd0);
      chk({tag, "_state_idle"}, 64'(st8), 64'd0);
    end
  endtask

  // One WIDTH=4 unsigned operation with out_ready held high.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                     input string tag);
    int lat;
    chk({tag, "_in_ready"}, 64'(ir4), 64'd1);
    iv4 = 1'b1; a4 = a; b4 = b; s4 = 1'b0; or4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_product"}, 64'(p4), 64'(exp));
    // Handshake lands on the next edge: WIDTH+1 edges after accept.
    @(posedge clk); #1;
    chk({tag, "_ii_in_ready"}, 64'(ir4), 64'd1);
  endtask

  initial begin
    logic [7:0] e4;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid8", 64'(ov8), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_product8", 64'(p8), 64'd0);
    chk("rst_out_valid4", 64'(ov4), 64'd0);
    chk("rst_product4", 64'(p4), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_in_ready8", 64'(ir8), 64'd1);
    chk("rel_state8", 64'(st8), 64'd0);

    // Signed and unsigned corners
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_min", 0, 1'b0);
    op8(8'h80, 8'h7F, 1'b1, 16'hC080, "s_min_max", 0, 1'b0);
    op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1_1", 0, 1'b0);
    op8(8'h00, 8'hFB, 1'b1, 16'h0000, "s_0_m5", 0, 1'b0);
    op8(8'h7F, 8'h7F, 1'b1, 16'h3F01, "s_max_max", 0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255_255", 0, 1'b0);
    op8(8'hC8, 8'h03, 1'b0, 16'h0258, "u_200_3", 0, 1'b0);

    // Backpressure: 10 stalled cycles in DONE
    op8(8'd10, 8'd12, 1'b0, 16'h0078, "bp", 10, 1'b0);

    // Inputs churned during CALC: -3 * 5 = -15
    op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "ignored", 0, 1'b1);

    // Reset in the third CALC cycle
    iv8 = 1'b1; a8 = 8'd100; b8 = 8'd100; s8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("midrst_busy_before", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov8), 64'd0);
    chk("midrst_product", 64'(p8), 64'd0);
    chk("midrst_busy", 64'(busy8), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(ir8), 64'd1);
    op8(8'd7, 8'd9, 1'b0, 16'h003F, "post_rst", 0, 1'b0);

    // Exhaustive WIDTH=4 unsigned
    op4(4'hF, 4'hF, 8'hE1, "u4_15_15");
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        e4 = 8'(i) * 8'(j);
        op4(4'(i), 4'(j), e4, $sformatf("u4_%0d_%0d", i, j));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
